// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: FSM states, opcodes,
// ALU control codes, datapath mux encodings and the bundled control word.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL, S_ERROR
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/riscv_alu_decoder.sv
// ALU decoder shared with the single-cycle core: ALUOp plus instruction fields
// select the ALU operation.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only for R-type; addi with imm[10]=1 must still add
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multicycle RISC-V core with memory wait-state timeout.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W    = 3,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [1:0]           result_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal,
  output logic                 bus_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          instret_cnt
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state, state_next;
  ctrl_t      ctrl, ctrl_out;
  logic [7:0] wait_cnt;
  logic       stall, timeout;
  logic [2:0] alu_ctl;

  assign stall   = ctrl.mem_req & ~mem_ready;
  // the stall in progress is the MEM_WAIT_MAX-th consecutive one
  assign timeout = stall & (wait_cnt == WAIT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (stall)          wait_cnt <= wait_cnt + 8'd1;
      else if (mem_ready) wait_cnt <= '0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        if (mem_ready)    state_next = S_DECODE;
        else if (timeout) state_next = S_ERROR;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_B;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
        state_next     = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready)    state_next = S_MEMWB;
        else if (timeout) state_next = S_ERROR;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
        if (mem_ready)    state_next = S_FETCH;
        else if (timeout) state_next = S_ERROR;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        state_next      = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
        state_next      = S_FETCH;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        state_next      = S_ALUWB;
      end
      S_ILLEGAL, S_ERROR: state_next = state;
      default:            state_next = S_ERROR;
    endcase
  end

  riscv_alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (opcode[5]),
    .alu_control (alu_ctl)
  );

  // Reset forces every output low combinationally, dropping any request at once.
  assign ctrl_out    = rst ? '0 : ctrl;
  assign mem_req     = ctrl_out.mem_req;
  assign mem_write   = ctrl_out.mem_write;
  assign adr_src     = ctrl_out.adr_src;
  assign ir_write    = ctrl_out.ir_write;
  assign pc_write    = ctrl_out.pc_write;
  assign reg_write   = ctrl_out.reg_write;
  assign alu_src_a   = ctrl_out.alu_src_a;
  assign alu_src_b   = ctrl_out.alu_src_b;
  assign imm_src     = ctrl_out.imm_src;
  assign result_src  = ctrl_out.result_src;
  assign alu_control = rst ? '0 : ALUCTRL_W'(alu_ctl);
  assign illegal     = ~rst & (state == S_ILLEGAL);
  assign bus_err     = ~rst & (state == S_ERROR);

`ifdef CTRL_PERF_CNT_EN
  logic retire, frozen;

  assign frozen = (state == S_ILLEGAL) | (state == S_ERROR);
  assign retire = (state == S_MEMWB) | (state == S_ALUWB) | (state == S_BEQ) |
                  ((state == S_MEMWRITE) & mem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (!frozen) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: per-cycle expected control words are
// queued as stimulus is applied and compared against the DUT outputs.
module tb_riscv_multicycle_ctrl;

  typedef enum {P_RST, P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_WB,
                P_BEQ, P_JAL, P_ILL, P_ERR} phase_t;

  typedef struct {
    string       tag;
    logic [18:0] value;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_control;
  logic       illegal, bus_err;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  logic [18:0] obs;
  logic [2:0]  exp_alu;
  logic [1:0]  exp_imm;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.ALUCTRL_W(3), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .alu_control(alu_control), .illegal(illegal),
    .bus_err(bus_err)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, imm_src, result_src, alu_control, illegal, bus_err};

  function automatic logic [18:0] o(input logic req, input logic wr, input logic adr,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic [1:0] sa, input logic [1:0] sb_sel,
                                    input logic [1:0] imm, input logic [1:0] res,
                                    input logic [2:0] alu, input logic ill, input logic be);
    return {req, wr, adr, irw, pcw, rw, sa, sb_sel, imm, res, alu, ill, be};
  endfunction

  // Expected control word for each FSM step, taken from the control table.
  function automatic logic [18:0] ph(input phase_t p, input logic rdy, input logic z,
                                     input logic [2:0] alu, input logic [1:0] imm);
    case (p)
      P_F:   ph = o(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
      P_D:   ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
      P_MA:  ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, imm,   2'b00, 3'b000, 1'b0, 1'b0);
      P_MR:  ph = o(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
      P_MWB: ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0);
      P_MW:  ph = o(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
      P_ER:  ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, alu,    1'b0, 1'b0);
      P_EI:  ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, alu,    1'b0, 1'b0);
      P_WB:  ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
      P_BEQ: ph = o(1'b0, 1'b0, 1'b0, 1'b0, z,    1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0);
      P_JAL: ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
      P_ILL: ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
      P_ERR: ph = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
      default: ph = '0;
    endcase
  endfunction

  // One clock cycle: apply mem_ready, queue the expectation, compare mid-cycle.
  task automatic step(input string tag, input phase_t p, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    sb.push_back('{tag: tag, value: ph(p, rdy, zero, exp_alu, exp_imm)});
    #1;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.value) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", e.tag, obs, e.value);
    end
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z);
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("rst_mid", P_RST, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1; exp_alu = 3'b000; exp_imm = 2'b00;
    set_ir(7'b0000000, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    step("rst0", P_RST, 1'b1);
    step("rst1", P_RST, 1'b1);
    rst = 1'b0;

    // lw with three wait states in MEMREAD: 8 cycles
    set_ir(7'b0000011, 3'b010, 1'b0, 1'b0); exp_imm = 2'b00;
    step("lw_fetch", P_F, 1'b1);
    step("lw_decode", P_D, 1'b1);
    step("lw_memadr", P_MA, 1'b1);
    for (int i = 0; i < 3; i++) step("lw_memread_wait", P_MR, 1'b0);
    step("lw_memread", P_MR, 1'b1);
    step("lw_memwb", P_MWB, 1'b1);

    // sw, zero-wait: 4 cycles
    set_ir(7'b0100011, 3'b010, 1'b0, 1'b0); exp_imm = 2'b01;
    step("sw_fetch", P_F, 1'b1);
    step("sw_decode", P_D, 1'b1);
    step("sw_memadr", P_MA, 1'b1);
    step("sw_memwrite", P_MW, 1'b1);

    // beq taken, then not taken
    set_ir(7'b1100011, 3'b000, 1'b0, 1'b1);
    step("beq1_fetch", P_F, 1'b1);
    step("beq1_decode", P_D, 1'b1);
    step("beq1_taken", P_BEQ, 1'b1);
    set_ir(7'b1100011, 3'b000, 1'b0, 1'b0);
    step("beq0_fetch", P_F, 1'b1);
    step("beq0_decode", P_D, 1'b1);
    step("beq0_not_taken", P_BEQ, 1'b1);

    // R-type sub, then addi with the same funct3/funct7b5 bits
    set_ir(7'b0110011, 3'b000, 1'b1, 1'b0); exp_alu = 3'b001;
    step("sub_fetch", P_F, 1'b1);
    step("sub_decode", P_D, 1'b1);
    step("sub_exec", P_ER, 1'b1);
    step("sub_wb", P_WB, 1'b1);
    set_ir(7'b0010011, 3'b000, 1'b1, 1'b0); exp_alu = 3'b000;
    step("addi_fetch", P_F, 1'b1);
    step("addi_decode", P_D, 1'b1);
    step("addi_exec", P_EI, 1'b1);
    step("addi_wb", P_WB, 1'b1);

    // remaining ALU functions through both execute paths
    set_ir(7'b0110011, 3'b110, 1'b0, 1'b0); exp_alu = 3'b011;
    step("or_fetch", P_F, 1'b1); step("or_decode", P_D, 1'b1);
    step("or_exec", P_ER, 1'b1); step("or_wb", P_WB, 1'b1);
    set_ir(7'b0110011, 3'b111, 1'b0, 1'b0); exp_alu = 3'b010;
    step("and_fetch", P_F, 1'b1); step("and_decode", P_D, 1'b1);
    step("and_exec", P_ER, 1'b1); step("and_wb", P_WB, 1'b1);
    set_ir(7'b0010011, 3'b010, 1'b0, 1'b0); exp_alu = 3'b101;
    step("slti_fetch", P_F, 1'b1); step("slti_decode", P_D, 1'b1);
    step("slti_exec", P_EI, 1'b1); step("slti_wb", P_WB, 1'b1);
    set_ir(7'b0110011, 3'b100, 1'b0, 1'b0); exp_alu = 3'b000;
    step("xor_fetch", P_F, 1'b1); step("xor_decode", P_D, 1'b1);
    step("xor_exec_add", P_ER, 1'b1); step("xor_wb", P_WB, 1'b1);

    // jal
    set_ir(7'b1101111, 3'b000, 1'b0, 1'b0);
    step("jal_fetch", P_F, 1'b1);
    step("jal_decode", P_D, 1'b1);
    step("jal_exec", P_JAL, 1'b1);
    step("jal_wb", P_WB, 1'b1);

    // lui is unsupported: terminal ILLEGAL until reset
    set_ir(7'b0110111, 3'b000, 1'b0, 1'b0);
    step("lui_fetch", P_F, 1'b1);
    step("lui_decode", P_D, 1'b1);
    for (int i = 0; i < 20; i++) step("illegal_hold", P_ILL, i[0]);
    do_reset();

    // fetch stalled MEM_WAIT_MAX cycles: bus error
    set_ir(7'b0110011, 3'b000, 1'b0, 1'b0); exp_alu = 3'b000;
    for (int i = 0; i < 15; i++) step("fetch_stall", P_F, 1'b0);
    step("bus_err0", P_ERR, 1'b0);
    step("bus_err1", P_ERR, 1'b1);
    step("bus_err2", P_ERR, 1'b0);
    do_reset();
    step("after_err_fetch", P_F, 1'b1);
    step("after_err_decode", P_D, 1'b1);
    step("after_err_exec", P_ER, 1'b1);
    step("after_err_wb", P_WB, 1'b1);

    // ready arrives on the last allowed stall cycle: no error
    for (int i = 0; i < 14; i++) step("fetch_wait", P_F, 1'b0);
    step("fetch_ready_at_limit", P_F, 1'b1);
    step("limit_decode", P_D, 1'b1);
    step("limit_exec", P_ER, 1'b1);
    step("limit_wb", P_WB, 1'b1);

    // reset in the middle of a stalled access drops the request
    step("stall_before_rst", P_F, 1'b0);
    rst = 1'b1;
    step("rst_drops_req", P_RST, 1'b0);
    rst = 1'b0;
    step("post_rst_fetch", P_F, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
